// File: rtl/emg_tdm_sched.sv
// emg_tdm_sched: time-multiplexed scheduler sharing one hp/lp EMG filter among NCH channels
//   clk          system clock
//   reset        synchronous active-high reset
//   tick         frame strobe; latches i_spk_cnt and starts a frame when idle
//   i_spk_cnt    packed spike counts, channel k at [k*(NN+1) +: NN+1]
//   clr_state    zero every channel's hp/lp state (only acted on while idle)
//   busy         high whenever a frame is in progress
//   emg_out      signed 18-bit EMG sample for channel emg_ch
//   emg_valid    one-cycle qualifier for emg_out/emg_ch
//   emg_ch       channel of the current emg_out
//   frame_done   one-cycle pulse alongside the last channel's sample
//   overrun_cnt  saturating count of ticks dropped while busy
// Build option EMG_SAT_EN: saturate emg_out instead of truncating the 36-bit difference.
module emg_tdm_sched #(
    parameter int NCH = 4,
    parameter int NN  = 8,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [NCH*(NN+1)-1:0]   i_spk_cnt,
    input  logic                    clr_state,
    output logic                    busy,
    output logic signed [17:0]      emg_out,
    output logic                    emg_valid,
    output logic [CHW-1:0]          emg_ch,
    output logic                    frame_done,
    output logic [7:0]              overrun_cnt
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t state;
    logic [CHW-1:0] ch;
    logic [NN:0] cnt_lat [NCH];
    logic signed [35:0] hp_mem [NCH];
    logic signed [35:0] lp_mem [NCH];
    logic signed [35:0] hp_op, lp_op;
    logic [NN:0] cnt_op;
    logic signed [35:0] stim, hp_nx, lp_nx, diff;
    logic signed [17:0] emg_nx;
    localparam logic signed [35:0] SMAX = 36'sd131071;
    localparam logic signed [35:0] SMIN = -36'sd131072;
    assign stim  = 36'(cnt_op) << 8;
    assign hp_nx = hp_op + (stim >>> 4) - (hp_op >>> 4);
    assign lp_nx = lp_op - (lp_op >>> 2) + (stim >>> 2);
    assign diff  = lp_nx - hp_nx;
`ifdef EMG_SAT_EN
    assign emg_nx = (diff > SMAX) ? 18'sh1FFFF : (diff < SMIN) ? 18'sh20000 : diff[17:0];
`else
    assign emg_nx = diff[17:0];
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ch          <= '0;
            busy        <= 1'b0;
            emg_valid   <= 1'b0;
            frame_done  <= 1'b0;
            emg_out     <= '0;
            emg_ch      <= '0;
            overrun_cnt <= '0;
            for (int k = 0; k < NCH; k++) begin
                hp_mem[k] <= '0;
                lp_mem[k] <= '0;
            end
        end else begin
            emg_valid  <= 1'b0;
            frame_done <= 1'b0;
            // every state but IDLE drops ticks, DONE included
            if (tick && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            case (state)
                IDLE: begin
                    // clearing and starting in the same cycle is safe: RD reads a cycle later
                    if (clr_state)
                        for (int k = 0; k < NCH; k++) begin
                            hp_mem[k] <= '0;
                            lp_mem[k] <= '0;
                        end
                    if (tick) begin
                        for (int k = 0; k < NCH; k++)
                            cnt_lat[k] <= i_spk_cnt[k*(NN+1) +: NN+1];
                        ch    <= '0;
                        busy  <= 1'b1;
                        state <= RD;
                    end
                end
                RD: begin
                    hp_op  <= hp_mem[ch];
                    lp_op  <= lp_mem[ch];
                    cnt_op <= cnt_lat[ch];
                    state  <= WR;
                end
                WR: begin
                    hp_mem[ch] <= hp_nx;
                    lp_mem[ch] <= lp_nx;
                    emg_out    <= emg_nx;
                    emg_ch     <= ch;
                    emg_valid  <= 1'b1;
                    if (ch == CHW'(NCH - 1)) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        ch    <= ch + CHW'(1);
                        state <= RD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_emg_tdm_sched.sv
// tb_emg_tdm_sched: randomized self-checking bench for emg_tdm_sched against a per-frame reference model
module tb_emg_tdm_sched;
    localparam int NCH = 4;
    localparam int NN  = 10;
    localparam int CHW = 2;
    localparam int W   = NCH * (NN + 1);

    logic clk = 1'b0;
    logic reset, tick, clr_state;
    logic [W-1:0] i_spk_cnt;
    logic busy, emg_valid, frame_done;
    logic signed [17:0] emg_out;
    logic [CHW-1:0] emg_ch;
    logic [7:0] overrun_cnt;

    int n_chk = 0;
    int n_fail = 0;
    logic signed [35:0] m_hp [NCH];
    logic signed [35:0] m_lp [NCH];
    logic [NN:0] cnt_in [NCH];
    logic signed [17:0] exp_o [NCH];
    logic signed [17:0] last_out;
    logic [CHW-1:0] last_ch;
    int exp_ovr;

    emg_tdm_sched #(.NCH(NCH), .NN(NN), .CHW(CHW)) dut (
        .clk(clk), .reset(reset), .tick(tick), .i_spk_cnt(i_spk_cnt), .clr_state(clr_state),
        .busy(busy), .emg_out(emg_out), .emg_valid(emg_valid), .emg_ch(emg_ch),
        .frame_done(frame_done), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [17:0] out18(input logic signed [35:0] d);
`ifdef EMG_SAT_EN
        if (d > 131071) return 18'sh1FFFF;
        if (d < -131072) return 18'sh20000;
`endif
        return d[17:0];
    endfunction

    function automatic void model_zero();
        for (int k = 0; k < NCH; k++) begin
            m_hp[k] = '0;
            m_lp[k] = '0;
        end
    endfunction

    // one frame of the filter: every channel advances once on its latched count
    function automatic void model_frame();
        logic signed [35:0] stim, nhp, nlp;
        for (int k = 0; k < NCH; k++) begin
            stim = 36'(cnt_in[k]) * 256;
            nhp = m_hp[k] + stim / 16 - (m_hp[k] >>> 4);
            nlp = m_lp[k] - (m_lp[k] >>> 2) + stim / 4;
            m_hp[k] = nhp;
            m_lp[k] = nlp;
            exp_o[k] = out18(nlp - nhp);
        end
    endfunction

    function automatic void rand_counts();
        for (int k = 0; k < NCH; k++) cnt_in[k] = (NN+1)'($urandom);
    endfunction

    function automatic void set_counts(input int c0);
        for (int k = 0; k < NCH; k++) cnt_in[k] = '0;
        cnt_in[0] = (NN+1)'(c0);
    endfunction

    // drive one tick and check every cycle of the frame; xtick/xclr inject a stray
    // tick or clr_state a given number of cycles after the accepted tick
    task automatic frame(input logic clr_with, input int xtick, input int xclr);
        logic v;
        for (int k = 0; k < NCH; k++) i_spk_cnt[k*(NN+1) +: NN+1] = cnt_in[k];
        tick = 1'b1;
        clr_state = clr_with;
        if (clr_with) model_zero();
        model_frame();
        @(negedge clk);
        for (int j = 0; j <= 2*NCH + 1; j++) begin
            v = (j >= 2 && j <= 2*NCH && j % 2 == 0);
            chk("emg_valid", emg_valid, v);
            chk("frame_done", frame_done, j == 2*NCH);
            chk("busy", busy, j <= 2*NCH);
            if (v) begin
                last_out = exp_o[(j-2)/2];
                last_ch = CHW'((j-2)/2);
            end
            chk("emg_out", emg_out, last_out);
            chk("emg_ch", emg_ch, last_ch);
            chk("overrun_cnt", overrun_cnt, exp_ovr);
            i_spk_cnt = W'({$urandom, $urandom});
            tick = (j == xtick && j <= 2*NCH);
            clr_state = (j == xclr && j <= 2*NCH);
            if (tick && exp_ovr < 255) exp_ovr++;
            @(negedge clk);
        end
        tick = 1'b0;
        clr_state = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        clr_state = 1'b0;
        i_spk_cnt = '0;
        model_zero();
        last_out = '0;
        last_ch = '0;
        exp_ovr = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", emg_valid, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_out", emg_out, 0);
        chk("rst_ch", emg_ch, 0);
        chk("rst_ovr", overrun_cnt, 0);
        reset = 1'b0;
        @(negedge clk);

        set_counts(1);
        frame(1'b0, -1, -1);
        set_counts(0);
        frame(1'b0, -1, -1);
        rand_counts();
        frame(1'b0, 3, -1);
        set_counts(2047);
        frame(1'b1, -1, -1);
        frame(1'b0, -1, -1);
        for (int i = 0; i < 6; i++) begin
            rand_counts();
            frame(1'($urandom), $urandom_range(0, 12), $urandom_range(0, 12));
        end

        set_counts(3);
        for (int k = 0; k < NCH; k++) i_spk_cnt[k*(NN+1) +: NN+1] = cnt_in[k];
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_zero();
        last_out = '0;
        last_ch = '0;
        exp_ovr = 0;
        for (int j = 0; j < 10; j++) begin
            chk("abort_valid", emg_valid, 0);
            chk("abort_done", frame_done, 0);
            chk("abort_busy", busy, 0);
            chk("abort_out", emg_out, 0);
            chk("abort_ovr", overrun_cnt, 0);
            @(negedge clk);
        end
        set_counts(1);
        frame(1'b0, -1, -1);

        clr_state = 1'b1;
        @(negedge clk);
        clr_state = 1'b0;
        model_zero();
        set_counts(0);
        frame(1'b0, -1, -1);

        tick = 1'b1;
        repeat (350) @(negedge clk);
        tick = 1'b0;
        repeat (12) @(negedge clk);
        chk("ovr_sat", overrun_cnt, 255);
        chk("ovr_idle", busy, 0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_zero();
        last_out = '0;
        last_ch = '0;
        exp_ovr = 0;
        @(negedge clk);
        rand_counts();
        frame(1'b0, 5, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
